// File: rtl/imem_loader_if.sv
// Instruction-memory write port driven by the boot loader.
// One-cycle write strobe with address and data; the memory cannot stall it.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (output imem_we, imem_addr, imem_wdata);
  modport slave  (input  imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader.sv
// UART (8N1) boot loader: packs bytes little-endian into words written from address 0, holding the core in reset.
// Write lands 1 cycle after the 4th byte's stop bit; no backpressure, the memory accepts every strobe.
module imem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_WIDTH   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  imem_loader_if.master     imem,
  output logic              core_rst,
  output logic              loading,
  output logic              done,
  output logic              frame_err,
  output logic [ADDR_WIDTH:0] word_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  uart_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic          rx_meta, rx_s;
  logic          byte_vld, stop_bad;
  logic [1:0]    lane;
  logic [23:0]   word_lo;

  assign loading  = ~done;
  assign core_rst = ~done;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
    end
  end

  // Bits are sampled mid-cell: half a bit into the start bit, then every full bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    byte_vld  = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s && loading) begin
          state_d   = START;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          sh_d      = {rx_s, sh_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (loading) begin
            byte_vld = rx_s;
            stop_bad = ~rx_s;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Word assembly, write strobe and completion tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane            <= '0;
      word_lo         <= '0;
      imem.imem_we    <= 1'b0;
      imem.imem_addr  <= '0;
      imem.imem_wdata <= '0;
      word_count      <= '0;
      done            <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      imem.imem_we <= 1'b0;
      if (byte_vld) begin
        lane <= lane + 2'd1;
        case (lane)
          2'd0: word_lo[7:0]   <= sh_q;
          2'd1: word_lo[15:8]  <= sh_q;
          2'd2: word_lo[23:16] <= sh_q;
          default: begin
            imem.imem_we    <= 1'b1;
            imem.imem_wdata <= {sh_q, word_lo};
            imem.imem_addr  <= word_count[ADDR_WIDTH-1:0];
          end
        endcase
      end
      if (imem.imem_we) begin
        word_count <= word_count + 1'b1;
        // The top address write always ends loading, so the address never wraps.
        if (imem.imem_wdata == 32'h0 || word_count[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}})
          done <= 1'b1;
      end
      if (stop_bad) frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader; a byte-level model predicts every memory write and the sticky status.
module tb_imem_loader;

  localparam int CPB = 4;
  localparam int AW  = 5;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b1;
  logic core_rst, loading, done, frame_err;
  logic [AW:0] word_count;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .imem       (bus.master),
    .core_rst   (core_rst),
    .loading    (loading),
    .done       (done),
    .frame_err  (frame_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  wr_t        exp_q[$];
  wr_t        dut_log[$];
  logic [7:0] m_bytes[$];
  int         m_wc;
  bit         m_done;
  bit         m_ferr;
  logic       prev_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: a word exists once four good bytes arrive; stop feeding it once loading ends.
  task automatic model_byte(input logic [7:0] b, input bit ok);
    wr_t e;
    if (m_done) return;
    if (!ok) begin
      m_ferr = 1'b1;
      return;
    end
    m_bytes.push_back(b);
    if (m_bytes.size() == 4) begin
      e.addr = AW'(m_wc);
      e.data = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
      exp_q.push_back(e);
      m_bytes.delete();
      m_wc++;
      if (e.data == 32'h0 || m_wc == (1 << AW)) m_done = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (bus.imem_we) begin
      chk("we_back_to_back", 32'(prev_we), 32'd0);
      chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        chk("write_addr", 32'(bus.imem_addr), 32'(exp_q[0].addr));
        chk("write_data", bus.imem_wdata, exp_q[0].data);
        void'(exp_q.pop_front());
      end
      dut_log.push_back({bus.imem_addr, bus.imem_wdata});
    end
    prev_we = bus.imem_we;
  end

  task automatic send_byte(input logic [7:0] b, input bit ok, input int gap);
    model_byte(b, ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (ok ? gap : gap + 3 * CPB) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8], 1'b1, int'($urandom_range(0, 3)));
  endtask

  task automatic do_reset();
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    dut_log.delete();
    m_bytes.delete();
    m_wc   = 0;
    m_done = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic check_state(input string pfx);
    repeat (6 * CPB) @(negedge clk);
    chk({pfx, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    chk({pfx, "_word_count"}, 32'(word_count), 32'(m_wc));
    chk({pfx, "_done"}, 32'(done), 32'(m_done));
    chk({pfx, "_core_rst"}, 32'(core_rst), 32'(!m_done));
    chk({pfx, "_loading"}, 32'(loading), 32'(!m_done));
    chk({pfx, "_frame_err"}, 32'(frame_err), 32'(m_ferr));
  endtask

  initial begin
    int nw;
    logic [31:0] w;

    // Reset values while rst is still asserted
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(bus.imem_we), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_wdata", bus.imem_wdata, 32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_loading", 32'(loading), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    do_reset();

    // Program word then terminator, second word sent back-to-back
    send_word(32'h0050_0293);
    for (int k = 0; k < 4; k++) send_byte(8'h00, 1'b1, 0);
    check_state("s2");
    chk("s2_nwrites", 32'(dut_log.size()), 32'd2);
    chk("s2_done_lit", 32'(done), 32'd1);
    if (dut_log.size() == 2) begin
      chk("s2_w0", {27'd0, dut_log[0].addr}, 32'd0);
      chk("s2_d0", dut_log[0].data, 32'h0050_0293);
      chk("s2_w1", {27'd0, dut_log[1].addr}, 32'd1);
      chk("s2_d1", dut_log[1].data, 32'h0000_0000);
    end

    // Bad stop bit is dropped and does not advance the lane
    do_reset();
    send_byte(8'h11, 1'b0, 0);
    send_word(32'h4433_2211);
    check_state("s3");
    chk("s3_frame_err_lit", 32'(frame_err), 32'd1);
    chk("s3_nwrites", 32'(dut_log.size()), 32'd1);
    if (dut_log.size() == 1) chk("s3_d0", dut_log[0].data, 32'h4433_2211);

    // One-cycle start glitch
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    check_state("s4");
    chk("s4_nwrites", 32'(dut_log.size()), 32'd1);

    // Fill all 32 words, then further bytes are ignored
    do_reset();
    for (int i = 0; i < 32; i++) send_word(32'(i + 1));
    check_state("s5");
    chk("s5_word_count_lit", 32'(word_count), 32'd32);
    send_word(32'hCAFE_F00D);
    send_byte(8'h55, 1'b0, 0);
    check_state("s5_after");
    chk("s5_nwrites", 32'(dut_log.size()), 32'd32);

    // Reset in the middle of a word
    do_reset();
    send_byte(8'hA1, 1'b1, 0);
    send_byte(8'hB2, 1'b1, 0);
    do_reset();
    send_word(32'hDEAD_BEEF);
    check_state("s6");
    chk("s6_done_lit", 32'(done), 32'd0);
    chk("s6_core_rst_lit", 32'(core_rst), 32'd1);
    if (dut_log.size() == 1) chk("s6_d0", dut_log[0].data, 32'hDEAD_BEEF);
    else chk("s6_nwrites", 32'(dut_log.size()), 32'd1);

    // Randomized streams: zero words, bad stops and trailing partial words
    for (int r = 0; r < 5; r++) begin
      do_reset();
      nw = int'($urandom_range(2, 10));
      for (int j = 0; j < nw; j++) begin
        w = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
        for (int k = 0; k < 4; k++) begin
          if ($urandom_range(0, 9) == 0) send_byte(8'($urandom), 1'b0, 0);
          send_byte(w[k*8 +: 8], 1'b1, int'($urandom_range(0, 3)));
        end
      end
      if (r % 2 == 1)
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) send_byte(8'($urandom), 1'b1, 1);
      check_state("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete, compared %0d", cmp_cnt);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Serial boot loader that fills the instruction memory before the multicycle RISC-V core runs. It receives UART bytes on `rx` (8N1, LSB first) and packs them little-endian into 32-bit words. Each word is written to consecutive instruction-memory addresses starting at 0. While loading, it holds the core in reset. It releases the core once a zero terminator word arrives (the core's halt instruction) or the memory is full.

## Interface
Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be ≥ 4.
- ADDR_WIDTH, 5, instruction-memory word-address width (32 words).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- rx  in  1  UART serial input; idle high; asynchronous to clk.
- imem_we  out  1  one-cycle write strobe to the instruction memory.
- imem_addr  out  ADDR_WIDTH  word address of the current write.
- imem_wdata  out  32  word being written.
- core_rst  out  1  reset to the core; high until loading completes.
- loading  out  1  high while accepting bytes.
- done  out  1  high once loading has completed; sticky until rst.
- frame_err  out  1  sticky: a byte with a bad stop bit was seen.
- word_count  out  ADDR_WIDTH+1  number of words written, including the terminator.

## Operation
**Reset.** On rst, every output takes its reset value: imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, loading=1, done=0, frame_err=0, word_count=0. Also:
- The byte lane index and the UART FSM (IDLE) are cleared.
- The synchronizer flops are set to 1.

**Input synchronizer.**
- `rx` passes through a 2-flop synchronizer, giving rx_s.
- All decisions use rx_s.

**UART FSM (states IDLE, START, DATA, STOP).**
- **IDLE:** when rx_s=0 → START, bit counter cleared.
- **START:** wait CLKS_PER_BIT/2 cycles, then sample rx_s.
  - rx_s=1 → glitch; return to IDLE, no byte produced.
  - rx_s=0 → DATA.
- **DATA:** every CLKS_PER_BIT cycles, sample one bit into the shift register, LSB first. After 8 bits → STOP.
- **STOP:** after CLKS_PER_BIT cycles, sample rx_s.
  - rx_s=1 → byte_valid pulses for 1 cycle.
  - rx_s=0 → frame_err set, byte discarded, lane index unchanged.
  - Both cases return to IDLE.

**Word assembly.**
- Byte k (k=0..3) goes into word bits [8k+7:8k].
- On the 4th valid byte, in the next cycle:
  - imem_we=1, imem_wdata = the assembled word, imem_addr = word_count[ADDR_WIDTH-1:0].
  - The lane index returns to 0.
- One cycle after the imem_we pulse, word_count increments. imem_addr holds its value until the next write.

**Completion.** Completion occurs in the same cycle word_count increments, when either:
- the written word was 0x00000000, or
- word_count reaches 2^ADDR_WIDTH.

On completion, done=1, loading=0 and core_rst=0 are set together.

**After completion.**
- rx is ignored: no byte_valid, no writes, no frame_err updates.
- Only rst restarts loading.

**Partial words.** A partial word (1–3 bytes) never writes. It stays pending indefinitely.

## Timing
- rx-to-FSM latency is 2 cycles (synchronizer).
- Start detect to byte_valid is ≈ CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles.
- byte_valid (4th byte) → imem_we takes 1 cycle. imem_we → word_count increment, and → done/core_rst change, take 1 cycle.
- imem_we is never high for two consecutive cycles. Back-to-back bytes (no idle gap after the stop bit) must be received correctly.
- Reset mid-byte or mid-word discards the partial data. There is no write in the cycle rst is high. After reset, a new byte starts cleanly on the next falling edge.
- The write for address 2^ADDR_WIDTH−1 completes loading even if the word is nonzero. No address wrap-around is ever written.

## Test plan
All scenarios use CLKS_PER_BIT=4 and ADDR_WIDTH=5.

1. **Reset values.** Hold rst 3 cycles with rx=1 → all outputs at their reset values; core_rst=1, loading=1.
2. **Two words and terminator.** Send bytes 0x93,0x02,0x50,0x00 then 0x00×4 →
   - write addr 0 data 0x00500293, then addr 1 data 0x00000000;
   - word_count=2, done=1, core_rst=0;
   - exactly 2 imem_we pulses.
3. **Bad stop bit.** Send 0x11 with stop bit=0, then 0x11,0x22,0x33,0x44 valid → frame_err=1; single write to addr 0 of 0x44332211; lane index unaffected by the bad byte.
4. **Start glitch.** Drive rx low for 1 bit-clock-quarter (1 cycle) then high → no byte_valid, FSM back in IDLE, no state change on outputs.
5. **Memory full.** Send 32 nonzero words (word i = i+1) →
   - 32 writes to addresses 0..31;
   - done=1 after the 32nd write, word_count=32;
   - further bytes produce no writes.
6. **Reset mid-word.** Send 2 bytes, pulse rst, then send 0xEF,0xBE,0xAD,0xDE → single write to addr 0 of 0xDEADBEEF, word_count=1, done=0, core_rst=1.
